mmio_uart_bridge: RTL and testbench

MMIO_UART_BRIDGE -- requirements
Module: mmio_uart_bridge

---
 rtl/mmio_pkg.sv | 34 +++
 rtl/uart_tx_fifo.sv | 74 +++++++
 rtl/mmio_uart_bridge.sv | 237 +++++++++++++++++++++++
 tb/tb_mmio_uart_bridge.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for mmio_uart_bridge: IO window, register offsets, STATUS layout, TX states.
// Optional build macro: MMIO_UART_PARITY_EN adds an even-parity bit to every frame.
package mmio_pkg;

    localparam logic [31:0] IO_BASE     = 32'hFFFF_0000;
    localparam logic [3:0]  OFF_PORTOUT = 4'h0;
    localparam logic [3:0]  OFF_PORTIN  = 4'h4;
    localparam logic [3:0]  OFF_TXDATA  = 4'h8;
    localparam logic [3:0]  OFF_STATUS  = 4'hC;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_MSB = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef MMIO_UART_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

`ifdef MMIO_UART_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; a push into a full FIFO succeeds only alongside a pop.
module uart_tx_fifo import mmio_pkg::*; #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [7:0]                   wdata,
    output logic [7:0]                   rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = FIFO_DEPTH[CW-1:0];

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s;
    logic          do_pop_s;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == {CW{1'b0}});
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // Accept/pop qualification, pointer wrap and occupancy update.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: 8'd0};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Memory-mapped IO block: output port, synchronized input port and a FIFO-buffered UART transmitter.
// Define MMIO_UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module mmio_uart_bridge import mmio_pkg::*; #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        IoHit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        UartTx
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam int          RELOAD_I   = CLKS_PER_BIT - 1;
    localparam logic [15:0] BIT_RELOAD = RELOAD_I[15:0];

    logic [31:0]   portout_q, portout_d;
    logic [7:0]    sync1_q, sync1_d;
    logic [7:0]    sync2_q, sync2_d;
    logic          ovf_q, ovf_d;
    tx_state_t     state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
`ifdef MMIO_UART_PARITY_EN
    logic          par_q, par_d;
`endif

    logic          io_hit_s;
    logic          wr_s;
    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [7:0]    fifo_rdata_s;
    logic [31:0]   status_s;

    assign io_hit_s = (Address[31:4] == IO_BASE[31:4]);
    assign wr_s     = MemWrite && io_hit_s;
    assign IoHit    = io_hit_s;
    assign PortOut  = portout_q;
    assign UartTx   = tx_q;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (WriteData[7:0]),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // STATUS register image.
    always_comb begin
        status_s                            = 32'd0;
        status_s[ST_COUNT_MSB:ST_COUNT_LSB] = 5'(fifo_count_s);
        status_s[ST_OVF]                    = ovf_q;
        status_s[ST_EMPTY]                  = fifo_empty_s;
        status_s[ST_FULL]                   = fifo_full_s;
        status_s[ST_BUSY]                   = (state_q != TX_IDLE);
    end

    // Load data mux; address bits [1:0] are don't-care within each word.
    always_comb begin
        ReadData = 32'd0;
        if (io_hit_s && MemRead) begin
            casez (Address[3:0])
                {OFF_PORTOUT[3:2], 2'b??}: ReadData = portout_q;
                {OFF_PORTIN[3:2],  2'b??}: ReadData = {24'd0, sync2_q};
                {OFF_STATUS[3:2],  2'b??}: ReadData = status_s;
                default:                   ReadData = 32'd0;
            endcase
        end else begin
            ReadData = 32'd0;
        end
    end

    // Store decode, input synchronizer and sticky overflow.
    always_comb begin
        portout_d = portout_q;
        push_s    = 1'b0;
        ovf_d     = ovf_q;
        sync1_d   = PortIn;
        sync2_d   = sync1_q;
        if (wr_s) begin
            casez (Address[3:0])
                {OFF_PORTOUT[3:2], 2'b??}: portout_d = WriteData;
                {OFF_TXDATA[3:2],  2'b??}: push_s    = 1'b1;
                {OFF_STATUS[3:2],  2'b??}: ovf_d     = 1'b0;
                default:                   push_s    = 1'b0;
            endcase
        end else begin
            push_s = 1'b0;
        end
        if (push_s && fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
    end

    // Transmit FSM: every non-idle state holds for CLKS_PER_BIT cycles via the down-counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        load_s  = 1'b0;
        pop_s   = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            TX_IDLE: begin
                load_s = !fifo_empty_s;
            end
            TX_START: begin
                if (cnt_q == 16'd0) begin
                    state_d = TX_DATA;
                    cnt_d   = BIT_RELOAD;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = TX_PARITY;
`else
                        state_d = TX_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`ifdef MMIO_UART_PARITY_EN
            TX_PARITY: begin
                if (cnt_q == 16'd0) begin
                    state_d = TX_STOP;
                    cnt_d   = BIT_RELOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            TX_STOP: begin
                if (cnt_q == 16'd0) begin
                    load_s  = !fifo_empty_s;
                    state_d = TX_IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Back-to-back frames reuse this path straight out of STOP.
        if (load_s) begin
            pop_s   = 1'b1;
            state_d = TX_START;
            cnt_d   = BIT_RELOAD;
            bit_d   = 3'd0;
            shift_d = fifo_rdata_s;
`ifdef MMIO_UART_PARITY_EN
            par_d   = even_parity(fifo_rdata_s);
`endif
        end else begin
            pop_s = 1'b0;
        end

        case (state_d)
            TX_START:  tx_d = 1'b0;
            TX_DATA:   tx_d = shift_d[0];
`ifdef MMIO_UART_PARITY_EN
            TX_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    // Bridge state registers; reset aborts any frame with the line forced idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            portout_q <= 32'd0;
            sync1_q   <= 8'd0;
            sync2_q   <= 8'd0;
            ovf_q     <= 1'b0;
            state_q   <= TX_IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
`ifdef MMIO_UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            portout_q <= portout_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef MMIO_UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Self-checking bench for mmio_uart_bridge: directed steps plus random traffic against a
// transaction-level model (register image, FIFO occupancy rule) and a line-level UART receiver.
module tb_mmio_uart_bridge;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef MMIO_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam logic [31:0] A_PORTOUT = 32'hFFFF_0000;
    localparam logic [31:0] A_PORTIN  = 32'hFFFF_0004;
    localparam logic [31:0] A_TXDATA  = 32'hFFFF_0008;
    localparam logic [31:0] A_STATUS  = 32'hFFFF_000C;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic [31:0] Address   = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite  = 1'b0;
    logic        MemRead   = 1'b0;
    logic [7:0]  PortIn    = 8'h81;
    logic [31:0] ReadData;
    logic        IoHit;
    logic [31:0] PortOut;
    logic        UartTx;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  rx_q [$];
    logic        rx_en    = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_stop_err;
    logic        rx_par_err;

    always #5 clk = ~clk;

    mmio_uart_bridge #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .IoHit     (IoHit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .UartTx    (UartTx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int level, input logic ovf, input logic busy);
        return (32'(level) << 4) | (ovf ? 32'h8 : 32'h0) | ((level == 0) ? 32'h4 : 32'h0)
             | ((level == DEPTH) ? 32'h2 : 32'h0) | (busy ? 32'h1 : 32'h0);
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef MMIO_UART_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Call at (or just after) a falling edge; returns just after the next falling edge.
    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d, output logic hit);
        Address = a;
        MemRead = 1'b1;
        #1;
        d       = ReadData;
        hit     = IoHit;
        MemRead = 1'b0;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b);
        logic [9:0] got;
        for (int c = 0; c < 30 * CPB * NBITS && rx_q.size() == 0; c++) @(negedge clk);
        if (rx_q.size() > 0) got = rx_q.pop_front();
        else                 got = 10'h3FF;
        check(tag, {22'd0, got}, {24'd0, b});
    endtask

    // Burst of n back-to-back TXDATA stores from an idle transmitter; model decides accept/drop.
    task automatic burst(input string tag, input int n);
        int          level;
        logic        idle, ovf, pop, hit;
        logic [7:0]  b;
        logic [7:0]  acc [$];
        logic [31:0] rd;
        level = 0;
        idle  = 1'b1;
        ovf   = 1'b0;
        for (int i = 0; i < n; i++) begin
            b   = 8'($urandom);
            pop = idle && (level > 0);
            if (pop) idle = 1'b0;
            if (level < DEPTH || pop) begin
                acc.push_back(b);
                level = level + 1;
            end else begin
                ovf = 1'b1;
            end
            if (pop) level = level - 1;
            mmio_write(A_TXDATA, {24'($urandom), b});
        end
        mmio_read(A_STATUS, rd, hit);
        check({tag, " status"}, rd, exp_status(level, ovf, !idle));
        if (ovf) begin
            @(negedge clk);
            mmio_write(A_STATUS, $urandom);
            mmio_read(A_STATUS, rd, hit);
            check({tag, " ovf clear"}, rd, exp_status(level, 1'b0, 1'b1));
        end
        while (acc.size() > 0) expect_rx({tag, " rx byte"}, acc.pop_front());
        repeat (2 * CPB) @(negedge clk);
        mmio_read(A_STATUS, rd, hit);
        check({tag, " idle status"}, rd, 32'h0000_0004);
    endtask

    // Line-level receiver: detect start, sample each bit mid-cell.
    initial begin : rx_monitor
        forever begin
            @(negedge clk);
            if (rx_en && !reset && UartTx === 1'b0) begin
                rx_stop_err = 1'b0;
                rx_par_err  = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                if (UartTx !== 1'b0) rx_stop_err = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    rx_byte[i] = UartTx;
                end
`ifdef MMIO_UART_PARITY_EN
                repeat (CPB) @(negedge clk);
                if (UartTx !== ^rx_byte) rx_par_err = 1'b1;
`endif
                repeat (CPB) @(negedge clk);
                if (UartTx !== 1'b1) rx_stop_err = 1'b1;
                rx_q.push_back({rx_par_err, rx_stop_err, rx_byte});
            end
        end
    end

    initial begin : main
        logic [31:0] rd;
        logic [31:0] v;
        logic        hit;
        int          bad;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset UartTx", {31'd0, UartTx}, 32'd1);
        check("reset PortOut", PortOut, 32'd0);
        mmio_read(A_STATUS, rd, hit);
        check("reset STATUS", rd, 32'h0000_0004);
        mmio_read(A_PORTIN, rd, hit);
        check("reset sync", rd, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // PORTOUT store/load and alias within the word
        mmio_write(A_PORTOUT, 32'hA5A5_0001);
        check("PortOut after store", PortOut, 32'hA5A5_0001);
        mmio_read(A_PORTOUT, rd, hit);
        check("PORTOUT load", rd, 32'hA5A5_0001);
        check("PORTOUT IoHit", {31'd0, hit}, 32'd1);
        mmio_read(32'hFFFF_0003, rd, hit);
        check("PORTOUT alias", rd, 32'hA5A5_0001);

        // PortIn two-stage latency
        @(negedge clk);
        PortIn = 8'h3C;
        mmio_read(A_PORTIN, rd, hit);
        check("PORTIN before edge", rd, 32'h0000_0081);
        @(negedge clk);
        mmio_read(A_PORTIN, rd, hit);
        check("PORTIN after 1 edge", rd, 32'h0000_0081);
        @(negedge clk);
        mmio_read(A_PORTIN, rd, hit);
        check("PORTIN after 2 edges", rd, 32'h0000_003C);

        // Reads returning zero
        mmio_read(A_TXDATA, rd, hit);
        check("TXDATA load", rd, 32'd0);
        Address = A_PORTOUT;
        MemRead = 1'b0;
        #1;
        check("no MemRead", ReadData, 32'd0);
        mmio_read(32'h1001_0000, rd, hit);
        check("miss ReadData", rd, 32'd0);
        check("miss IoHit", {31'd0, hit}, 32'd0);
        mmio_read(32'hFFFF_0010, rd, hit);
        check("edge miss IoHit", {31'd0, hit}, 32'd0);

        // Stores outside the window change nothing
        @(negedge clk);
        mmio_write(32'h1001_0000, 32'hDEAD_BEEF);
        mmio_write(32'hFFFF_0018, 32'h0000_00AA);
        repeat (2) @(negedge clk);
        check("miss PortOut", PortOut, 32'hA5A5_0001);
        check("miss UartTx", {31'd0, UartTx}, 32'd1);
        mmio_read(A_STATUS, rd, hit);
        check("miss STATUS", rd, 32'h0000_0004);

        // Exact waveform of one frame
        @(negedge clk);
        mmio_write(A_TXDATA, 32'h0000_0055);
        check("line before start", {31'd0, UartTx}, 32'd1);
        for (int k = 1; k <= NBITS * CPB; k++) begin
            @(negedge clk);
            check("frame 0x55 line", {31'd0, UartTx}, {31'd0, frame_bit(8'h55, (k - 1) / CPB)});
            if (k == 1) begin
                mmio_read(A_STATUS, rd, hit);
                check("busy STATUS", rd, exp_status(0, 1'b0, 1'b1));
            end
        end
        @(negedge clk);
        check("line after frame", {31'd0, UartTx}, 32'd1);
        mmio_read(A_STATUS, rd, hit);
        check("STATUS after frame", rd, 32'h0000_0004);
        expect_rx("rx 0x55", 8'h55);

        // Overflow: six stores back to back
        @(negedge clk);
        burst("ovf6", 6);

        // Random traffic
        for (int it = 0; it < 6; it++) begin
            @(negedge clk);
            v = $urandom;
            mmio_write(A_PORTOUT, v);
            check("rand PortOut", PortOut, v);
            mmio_read(A_PORTOUT, rd, hit);
            check("rand PORTOUT load", rd, v);
            @(negedge clk);
            v = {24'd0, 8'($urandom)};
            PortIn = v[7:0];
            repeat (2) @(negedge clk);
            mmio_read(A_PORTIN, rd, hit);
            check("rand PORTIN", rd, v);
            @(negedge clk);
            burst("rand burst", int'($urandom_range(1, 7)));
        end

        // Reset in the middle of data bit 3
        @(negedge clk);
        mmio_write(A_PORTOUT, 32'h1234_5678);
        PortIn = 8'hA7;
        mmio_write(A_TXDATA, 32'h0000_00F0);
        mmio_write(A_TXDATA, 32'h0000_0011);
        mmio_write(A_TXDATA, 32'h0000_0022);
        repeat (15) @(negedge clk);
        check("bit3 before reset", {31'd0, UartTx}, 32'd0);
        rx_en = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("async UartTx", {31'd0, UartTx}, 32'd1);
        check("reset PortOut mid", PortOut, 32'd0);
        mmio_read(A_STATUS, rd, hit);
        check("reset STATUS mid", rd, 32'h0000_0004);
        mmio_read(A_PORTIN, rd, hit);
        check("reset PORTIN mid", rd, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 3 * CPB * NBITS; c++) begin
            @(negedge clk);
            if (UartTx !== 1'b1) bad++;
        end
        check("queue discarded", 32'(bad), 32'd0);
        mmio_read(A_STATUS, rd, hit);
        check("STATUS after reset", rd, 32'h0000_0004);
        rx_q.delete();
        rx_en = 1'b1;

        @(negedge clk);
        burst("post reset", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
